// File: rtl/tri_setup_ctrl.sv
// tri_setup_ctrl: sequences triangle edge setup, culls, clips and forwards records to the rasterizer
module tri_setup_ctrl #(
  parameter int SCREEN_W  = 320,
  parameter int SCREEN_H  = 240,
  parameter int CULL_BACK = 0,
  parameter int TIMEOUT   = 8,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tri_valid,
  output logic                    tri_ready,
  input  logic [8:0]              v1x_in, v2x_in, v3x_in,
  input  logic [7:0]              v1y_in, v2y_in, v3y_in,
  output logic                    edge_start,
  input  logic                    edge_done,
  output logic [8:0]              ev1x, ev2x, ev3x,
  output logic [7:0]              ev1y, ev2y, ev3y,
  input  logic signed [9:0]       a1, b1, a2, b2, a3, b3,
  input  logic signed [17:0]      c1, c2, c3,
  input  logic [8:0]              bbxi, bbxf,
  input  logic [7:0]              bbyi, bbyf,
  output logic                    rast_valid,
  input  logic                    rast_ready,
  output logic signed [9:0]       ra1, rb1, ra2, rb2, ra3, rb3,
  output logic signed [17:0]      rc1, rc2, rc3,
  output logic [8:0]              rbbxi, rbbxf,
  output logic [7:0]              rbbyi, rbbyf,
  output logic signed [19:0]      area,
  output logic [CNT_W-1:0]        tri_count, cull_count,
  output logic                    err_timeout
);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, SETTLE, EVAL, OUTPUT} state_t;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [8:0] XM = 9'(SCREEN_W - 1);
  localparam logic [7:0] YM = 8'(SCREEN_H - 1);
  state_t state, nxt;
  logic [TW-1:0] tcnt;
  logic signed [19:0] sum;
  logic cull, timed_out;
  assign sum = {{2{rc1[17]}}, rc1} + {{2{rc2[17]}}, rc2} + {{2{rc3[17]}}, rc3};
  assign cull = sum == '0 || (CULL_BACK != 0 && sum[19]) || rbbxi > XM || rbbyi > YM;
  assign timed_out = !edge_done && tcnt == TW'(TIMEOUT);
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // next-state and handshake decode
  always_comb begin
    nxt = state;
    tri_ready = state == IDLE;
    edge_start = state == LAUNCH;
    rast_valid = state == OUTPUT;
    case (state)
      IDLE:    nxt = tri_valid ? LAUNCH : IDLE;
      LAUNCH:  nxt = WAIT;
      WAIT:    nxt = edge_done ? SETTLE : timed_out ? IDLE : WAIT;
      SETTLE:  nxt = EVAL;
      EVAL:    nxt = cull ? IDLE : OUTPUT;
      OUTPUT:  nxt = rast_ready ? IDLE : OUTPUT;
      default: nxt = IDLE;
    endcase
  end
  // vertex hold, coefficient capture, cull/clip and statistics
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {ev1x, ev2x, ev3x, ev1y, ev2y, ev3y} <= '0;
      {ra1, rb1, ra2, rb2, ra3, rb3, rc1, rc2, rc3} <= '0;
      {rbbxi, rbbxf, rbbyi, rbbyf, area} <= '0;
      {tri_count, cull_count, err_timeout, tcnt} <= '0;
    end else begin
      if (state == IDLE && tri_valid) begin
        {ev1x, ev2x, ev3x} <= {v1x_in, v2x_in, v3x_in};
        {ev1y, ev2y, ev3y} <= {v1y_in, v2y_in, v3y_in};
      end
      if (state == LAUNCH) tcnt <= '0;
      if (state == WAIT && !edge_done) begin
        if (timed_out) err_timeout <= 1'b1;
        else tcnt <= tcnt + TW'(1);
      end
      if (state == SETTLE) begin
        {ra1, rb1, ra2, rb2, ra3, rb3} <= {a1, b1, a2, b2, a3, b3};
        {rc1, rc2, rc3} <= {c1, c2, c3};
        {rbbxi, rbbxf, rbbyi, rbbyf} <= {bbxi, bbxf, bbyi, bbyf};
      end
      if (state == EVAL) begin
        area <= sum;
        if (cull) begin
          cull_count <= cull_count + CNT_W'(1);
          tri_count <= tri_count + CNT_W'(1);
        end else begin
          rbbxf <= rbbxf > XM ? XM : rbbxf;
          rbbyf <= rbbyf > YM ? YM : rbbyf;
        end
      end
      if (state == OUTPUT && rast_ready) tri_count <= tri_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_tri_setup_ctrl.sv
// tb_tri_setup_ctrl: randomized and directed checks of tri_setup_ctrl against a geometric reference model
module tb_tri_setup_ctrl;
  logic clk = 0, rst = 1, tri_valid = 0, edge_done = 0, rast_ready = 0, sel = 0;
  logic [8:0] v1x_in = 0, v2x_in = 0, v3x_in = 0, bbxi = 0, bbxf = 0;
  logic [7:0] v1y_in = 0, v2y_in = 0, v3y_in = 0, bbyi = 0, bbyf = 0;
  logic signed [9:0] a1 = 0, b1 = 0, a2 = 0, b2 = 0, a3 = 0, b3 = 0;
  logic signed [17:0] c1 = 0, c2 = 0, c3 = 0;
  logic [1:0] tri_ready, edge_start, rast_valid, err_timeout;
  logic [8:0] ev1x [2], ev2x [2], ev3x [2], rbbxi [2], rbbxf [2];
  logic [7:0] ev1y [2], ev2y [2], ev3y [2], rbbyi [2], rbbyf [2];
  logic signed [9:0] ra1 [2], rb1 [2], ra2 [2], rb2 [2], ra3 [2], rb3 [2];
  logic signed [17:0] rc1 [2], rc2 [2], rc3 [2];
  logic signed [19:0] area [2];
  logic [15:0] tri_count [2], cull_count [2];
  int n_chk = 0, n_fail = 0, fixed_d = 0, last_d = 0;
  int exp_tri [2] = '{0, 0}, exp_cull [2] = '{0, 0};
  bit no_setup = 0;

  typedef struct {
    int a1, b1, a2, b2, a3, b3, c1, c2, c3, area, xi, xf, yi, yf, cxf, cyf;
    bit cull;
  } rec_t;

  always #5 clk = ~clk;

  // instance 0 keeps back faces, instance 1 culls them; sel routes the upstream valid
  for (genvar g = 0; g < 2; g++) begin : g_dut
    tri_setup_ctrl #(.CULL_BACK(g)) dut (
      .clk(clk), .rst(rst), .tri_valid(tri_valid && (g == 1 ? sel : !sel)), .tri_ready(tri_ready[g]),
      .v1x_in(v1x_in), .v2x_in(v2x_in), .v3x_in(v3x_in), .v1y_in(v1y_in), .v2y_in(v2y_in), .v3y_in(v3y_in),
      .edge_start(edge_start[g]), .edge_done(edge_done),
      .ev1x(ev1x[g]), .ev2x(ev2x[g]), .ev3x(ev3x[g]), .ev1y(ev1y[g]), .ev2y(ev2y[g]), .ev3y(ev3y[g]),
      .a1(a1), .b1(b1), .a2(a2), .b2(b2), .a3(a3), .b3(b3), .c1(c1), .c2(c2), .c3(c3),
      .bbxi(bbxi), .bbxf(bbxf), .bbyi(bbyi), .bbyf(bbyf),
      .rast_valid(rast_valid[g]), .rast_ready(rast_ready),
      .ra1(ra1[g]), .rb1(rb1[g]), .ra2(ra2[g]), .rb2(rb2[g]), .ra3(ra3[g]), .rb3(rb3[g]),
      .rc1(rc1[g]), .rc2(rc2[g]), .rc3(rc3[g]),
      .rbbxi(rbbxi[g]), .rbbxf(rbbxf[g]), .rbbyi(rbbyi[g]), .rbbyf(rbbyf[g]),
      .area(area[g]), .tri_count(tri_count[g]), .cull_count(cull_count[g]), .err_timeout(err_timeout[g])
    );
  end

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int mn(input int p, input int q, input int r);
    int m = p;
    if (q < m) m = q;
    if (r < m) m = r;
    return m;
  endfunction

  function automatic int mx(input int p, input int q, input int r);
    int m = p;
    if (q > m) m = q;
    if (r > m) m = r;
    return m;
  endfunction

  // edge equations E(x,y)=a*x+b*y+c through consecutive vertices, plus cull and clip rules
  function automatic rec_t model(input int x1, y1, x2, y2, x3, y3, input bit cb);
    rec_t r;
    r.a1 = y1 - y2; r.b1 = x2 - x1; r.c1 = x1 * y2 - x2 * y1;
    r.a2 = y2 - y3; r.b2 = x3 - x2; r.c2 = x2 * y3 - x3 * y2;
    r.a3 = y3 - y1; r.b3 = x1 - x3; r.c3 = x3 * y1 - x1 * y3;
    r.area = r.c1 + r.c2 + r.c3;
    r.xi = mn(x1, x2, x3); r.xf = mx(x1, x2, x3);
    r.yi = mn(y1, y2, y3); r.yf = mx(y1, y2, y3);
    r.cxf = r.xf > 319 ? 319 : r.xf;
    r.cyf = r.yf > 239 ? 239 : r.yf;
    r.cull = r.area == 0 || (cb && r.area < 0) || r.xi >= 320 || r.yi >= 240;
    return r;
  endfunction

  // setup unit: answers edge_start after a delay; C arrives one cycle after edge_done
  initial begin
    rec_t s;
    int d;
    forever begin
      @(negedge clk);
      if (edge_start[sel] && !no_setup) begin
        s = model(ev1x[sel], ev1y[sel], ev2x[sel], ev2y[sel], ev3x[sel], ev3y[sel], 0);
        d = fixed_d >= 0 ? fixed_d : int'($urandom_range(0, 3));
        last_d = d;
        repeat (d + 1) @(negedge clk);
        edge_done = 1;
        {a1, b1, a2, b2, a3, b3} = {10'(s.a1), 10'(s.b1), 10'(s.a2), 10'(s.b2), 10'(s.a3), 10'(s.b3)};
        {bbxi, bbxf, bbyi, bbyf} = {9'(s.xi), 9'(s.xf), 8'(s.yi), 8'(s.yf)};
        {c1, c2, c3} = {18'($urandom), 18'($urandom), 18'($urandom)};
        @(negedge clk);
        edge_done = 0;
        {c1, c2, c3} = {18'(s.c1), 18'(s.c2), 18'(s.c3)};
      end
    end
  end

  task automatic accept(input int x1, y1, x2, y2, x3, y3);
    int k = 0;
    while (!tri_ready[sel] && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("accept_ready", tri_ready[sel], 1);
    {v1x_in, v2x_in, v3x_in} = {9'(x1), 9'(x2), 9'(x3)};
    {v1y_in, v2y_in, v3y_in} = {8'(y1), 8'(y2), 8'(y3)};
    tri_valid = 1;
    @(negedge clk);
    tri_valid = 0;
  endtask

  task automatic send(input int x1, y1, x2, y2, x3, y3, input int stall, input bit to);
    rec_t e;
    bit got = 0;
    int n = 1;
    e = model(x1, y1, x2, y2, x3, y3, sel);
    accept(x1, y1, x2, y2, x3, y3);
    while (n < 40 && !rast_valid[sel] && !tri_ready[sel]) begin
      @(negedge clk);
      n++;
    end
    chk("finish_bound", n < 40, 1);
    if (rast_valid[sel]) begin
      got = 1;
      chk("latency", n, 5 + last_d);
      chk("ra1", ra1[sel], e.a1); chk("rb1", rb1[sel], e.b1);
      chk("ra2", ra2[sel], e.a2); chk("rb2", rb2[sel], e.b2);
      chk("ra3", ra3[sel], e.a3); chk("rb3", rb3[sel], e.b3);
      chk("rc1", rc1[sel], e.c1); chk("rc2", rc2[sel], e.c2); chk("rc3", rc3[sel], e.c3);
      chk("area", area[sel], e.area);
      chk("rbbxi", rbbxi[sel], e.xi); chk("rbbxf", rbbxf[sel], e.cxf);
      chk("rbbyi", rbbyi[sel], e.yi); chk("rbbyf", rbbyf[sel], e.cyf);
      for (int i = 0; i < stall; i++) begin
        tri_valid = 1;
        v1x_in = 9'(x1 + 1);
        @(negedge clk);
        chk("stall_valid", rast_valid[sel], 1);
        chk("stall_ready", tri_ready[sel], 0);
        chk("stall_area", area[sel], e.area);
        chk("stall_rc2", rc2[sel], e.c2);
        chk("stall_xf", rbbxf[sel], e.cxf);
        chk("stall_ev1x", ev1x[sel], x1);
      end
      tri_valid = 0;
      rast_ready = 1;
      @(negedge clk);
      rast_ready = 0;
      chk("post_ready", tri_ready[sel], 1);
      chk("post_valid", rast_valid[sel], 0);
    end
    if (to) begin
      chk("err_timeout", err_timeout[sel], 1);
      chk("timeout_cycles", n >= 10 && n <= 12, 1);
    end else begin
      chk("err_clear", err_timeout[sel], 0);
      exp_tri[sel]++;
      if (e.cull) exp_cull[sel]++;
    end
    chk("record", got, !e.cull && !to);
    chk("tri_count", tri_count[sel], exp_tri[sel]);
    chk("cull_count", cull_count[sel], exp_cull[sel]);
  endtask

  initial begin
    int x1, y1, x2, y2, x3, y3;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_ready", tri_ready[g], 1); chk("rst_start", edge_start[g], 0);
      chk("rst_valid", rast_valid[g], 0); chk("rst_area", area[g], 0);
      chk("rst_tri", tri_count[g], 0); chk("rst_err", err_timeout[g], 0);
    end
    rst = 0;
    @(negedge clk);
    sel = 0;
    send(10, 10, 50, 10, 10, 40, 0, 0);
    send(10, 10, 10, 40, 50, 10, 0, 0);
    sel = 1;
    send(10, 10, 10, 40, 50, 10, 0, 0);
    send(10, 10, 50, 10, 10, 40, 1, 0);
    sel = 0;
    send(0, 0, 5, 5, 10, 10, 0, 0);
    send(330, 10, 340, 10, 330, 20, 0, 0);
    send(300, 200, 400, 200, 300, 250, 0, 0);
    send(10, 10, 50, 10, 10, 40, 10, 0);
    fixed_d = -1;
    for (int i = 0; i < 40; i++) begin
      sel = 1'($urandom_range(0, 1));
      x1 = $urandom_range(0, 400); y1 = $urandom_range(0, 250);
      x2 = $urandom_range(0, 400); y2 = $urandom_range(0, 250);
      x3 = i % 8 == 0 ? x1 : int'($urandom_range(0, 400));
      y3 = i % 8 == 0 ? y1 : int'($urandom_range(0, 250));
      send(x1, y1, x2, y2, x3, y3, $urandom_range(0, 2), 0);
    end
    sel = 0;
    no_setup = 1;
    send(20, 20, 60, 20, 20, 60, 0, 1);
    accept(20, 20, 60, 20, 20, 60);
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("mid_ready", tri_ready[0], 1); chk("mid_start", edge_start[0], 0);
    chk("mid_valid", rast_valid[0], 0); chk("mid_err", err_timeout[0], 0);
    chk("mid_tri", tri_count[0], 0); chk("mid_cull", cull_count[0], 0);
    chk("mid_tri1", tri_count[1], 0); chk("mid_area", area[0], 0);
    chk("mid_ev1x", ev1x[0], 0); chk("mid_rc1", rc1[0], 0);
    @(negedge clk);
    rst = 0;
    exp_tri = '{0, 0};
    exp_cull = '{0, 0};
    no_setup = 0;
    fixed_d = 0;
    @(negedge clk);
    send(10, 10, 50, 10, 10, 40, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
